// File: rtl/ram_banked_ctrl.sv
// Banked backing-store RAM with request/done handshake, fixed access
// latency, byte-enable writes and a write-invalidate port to the cache.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   req, mode           request strobe (IDLE only), 1=write 0=read
//   address, data       word address (mod DEPTH), write data
//   byte_en             write byte lanes
//   response, done      busy flag, one-cycle completion pulse
//   out                 registered read data, held until next read
//   inv_valid           one-cycle pulse on write commit
//   inv_index, inv_tag  committed address split for the cache
module ram_banked_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req,
  input  logic                             mode,
  input  logic [ADDR_W-1:0]                address,
  input  logic [DATA_W-1:0]                data,
  input  logic [DATA_W/8-1:0]              byte_en,
  output logic                             response,
  output logic                             done,
  output logic [DATA_W-1:0]                out,
  output logic                             inv_valid,
  output logic [INDEX_BITS-1:0]            inv_index,
  output logic [DEPTH_LOG2-INDEX_BITS-1:0] inv_tag
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_mode;
  logic [DEPTH_LOG2-1:0]   r_addr;
  logic [DATA_W-1:0]       r_data;
  logic [BE_W-1:0]         r_be;
  logic [DATA_W-1:0]       r_mem [DEPTH];

  logic w_accept;
  logic w_commit;
  logic w_dec;
  logic w_unused_addr;

  // Upper address bits are intentionally dropped (address mod DEPTH).
  assign w_unused_addr = ^address[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    w_dec    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_dec = 1'b1;
        end else begin
          w_commit = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign response  = (r_state == S_BUSY);
  assign done      = (r_state == S_DONE);
  assign inv_valid = (r_state == S_DONE) && r_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_mode    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_be      <= '0;
      out       <= '0;
      inv_index <= '0;
      inv_tag   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= CNT_INIT;
        r_mode <= mode;
        r_addr <= address[DEPTH_LOG2-1:0];
        r_data <= data;
        r_be   <= byte_en;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_mode) begin
        out <= r_mem[r_addr];
      end
      if (w_commit && r_mode) begin
        inv_index <= r_addr[INDEX_BITS-1:0];
        inv_tag   <= r_addr[DEPTH_LOG2-1:INDEX_BITS];
      end
    end
  end

  // Array is not reset; an async reset forces IDLE so no commit occurs.
  always_ff @(posedge clk) begin
    if (w_commit && r_mode) begin
      for (int i = 0; i < BE_W; i++) begin
        if (r_be[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

endmodule
